// File: rtl/litton_timing_pkg.sv
// Shared definitions for the serial word-timing generator: state enum,
// Gray phase sequence and default drum geometry.
package litton_timing_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    RUN      = 1'b1
  } state_e;

  // Phase pair sequence 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] PH_S0 = 2'b00;
  localparam logic [1:0] PH_S1 = 2'b01;
  localparam logic [1:0] PH_S2 = 2'b11;
  localparam logic [1:0] PH_S3 = 2'b10;

  localparam int DEF_WORD_BITS  = 40;
  localparam int DEF_ADDR_BITS  = 7;
  localparam int DEF_NUM_WORDS  = 128;
  localparam int DEF_SYNC_POS   = 31;
  localparam int DEF_ADDR_START = 32;

  function automatic logic [1:0] gray_step(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_S0:   nxt = PH_S1;
      PH_S1:   nxt = PH_S2;
      PH_S2:   nxt = PH_S3;
      default: nxt = PH_S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gray_phase_ctr.sv
// Two-bit Gray phase stepper; load to 00 has priority over a step.
module gray_phase_ctr
  import litton_timing_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_load,
  input  logic       i_step,
  output logic [1:0] o_ph
);

  logic [1:0] r_ph;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph <= PH_S0;
    end else if (i_en) begin
      if (i_load)      r_ph <= PH_S0;
      else if (i_step) r_ph <= gray_step(r_ph);
    end
  end

  assign o_ph = r_ph;

endmodule

// File: rtl/serial_word_timing_gen.sv
// Word-timing generator: bit/word counters, sync, serial address, phase pair,
// index lock and slip. SERIAL_WORD_ADDR_PARITY_EN adds a parity bit and PAR_ERR.
module serial_word_timing_gen
  import litton_timing_pkg::*;
#(
  parameter int WORD_BITS  = DEF_WORD_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int SYNC_POS   = DEF_SYNC_POS,
  parameter int ADDR_START = DEF_ADDR_START,
  localparam int CW        = $clog2(WORD_BITS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 RESYNC,
  output logic [CW-1:0]        BIT_CNT,
  output logic [ADDR_BITS-1:0] WORD_ADR,
  output logic                 WORD_START,
  output logic                 SYNC,
  output logic                 ADR_SER,
  output logic [1:0]           T_PH,
  output logic                 LOCK,
  output logic                 SLIP
`ifdef SERIAL_WORD_ADDR_PARITY_EN
  ,
  input  logic                 ADR_CHK,
  output logic                 PAR_ERR
`endif
);

`ifdef SERIAL_WORD_ADDR_PARITY_EN
  localparam int ADDR_END = ADDR_START + ADDR_BITS;
`else
  localparam int ADDR_END = ADDR_START + ADDR_BITS - 1;
`endif

  generate
    if (WORD_BITS < 16 || NUM_WORDS < 2 || NUM_WORDS > 2**ADDR_BITS ||
        ADDR_END > WORD_BITS - 1 || SYNC_POS + 2 > WORD_BITS - 1) begin : g_bad_param
      $fatal(1, "serial_word_timing_gen: illegal geometry parameters");
    end
  endgenerate

  state_e               r_state, w_state_nxt;
  logic [CW-1:0]        r_bit_cnt, w_bit_nxt;
  logic [ADDR_BITS-1:0] r_word_adr, w_adr_nxt;
  logic                 r_word_start, r_sync, r_adr_ser, r_slip;
  logic                 w_slip_nxt, w_ph_load, w_ph_step;
  logic                 w_lock_nxt, w_ws_nxt, w_sync_nxt, w_ser_nxt;
  logic                 w_wrap, w_last;

  assign w_wrap = (r_bit_cnt == CW'(WORD_BITS - 1));
  assign w_last = (r_word_adr == ADDR_BITS'(NUM_WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_adr_nxt   = r_word_adr;
    w_slip_nxt  = r_slip;
    w_ph_load   = 1'b0;
    w_ph_step   = 1'b0;
    case (r_state)
      UNLOCKED: begin
        if (RESYNC) begin
          w_state_nxt = RUN;
          w_bit_nxt   = '0;
          w_adr_nxt   = '0;
          w_ph_load   = 1'b1;
        end
      end
      default: begin
        // An index mark anywhere but the last bit of the last word is a slip
        if (RESYNC && !(w_wrap && w_last)) begin
          w_slip_nxt = 1'b1;
          w_bit_nxt  = '0;
          w_adr_nxt  = '0;
          w_ph_load  = 1'b1;
        end else if (w_wrap) begin
          w_bit_nxt = '0;
          w_adr_nxt = w_last ? '0 : r_word_adr + 1'b1;
          w_ph_step = 1'b1;
        end else begin
          w_bit_nxt = r_bit_cnt + 1'b1;
        end
      end
    endcase
  end

  // Output decode from next-state values so registered outputs line up with BIT_CNT
  always_comb begin
    w_lock_nxt = (w_state_nxt == RUN);
    w_ws_nxt   = w_lock_nxt && (w_bit_nxt == '0);
    w_sync_nxt = w_lock_nxt &&
                 (((w_bit_nxt >= CW'(SYNC_POS)) && (w_bit_nxt <= CW'(SYNC_POS + 2))) ||
                  (w_bit_nxt >= CW'(WORD_BITS - 2)));
    w_ser_nxt  = 1'b0;
    for (int i = 0; i < ADDR_BITS; i++) begin
      if (w_bit_nxt == CW'(ADDR_START + i)) w_ser_nxt = w_adr_nxt[i];
    end
`ifdef SERIAL_WORD_ADDR_PARITY_EN
    if (w_bit_nxt == CW'(ADDR_START + ADDR_BITS)) w_ser_nxt = ~^w_adr_nxt;
`endif
    w_ser_nxt = w_ser_nxt && w_lock_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= UNLOCKED;
      r_bit_cnt    <= '0;
      r_word_adr   <= '0;
      r_word_start <= 1'b0;
      r_sync       <= 1'b0;
      r_adr_ser    <= 1'b0;
      r_slip       <= 1'b0;
    end else if (EN) begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_word_adr   <= w_adr_nxt;
      r_word_start <= w_ws_nxt;
      r_sync       <= w_sync_nxt;
      r_adr_ser    <= w_ser_nxt;
      r_slip       <= w_slip_nxt;
    end
  end

`ifdef SERIAL_WORD_ADDR_PARITY_EN
  logic r_par_err;

  // ADR_CHK echoes the bit currently on ADR_SER
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_err <= 1'b0;
    end else if (EN) begin
      r_par_err <= (r_state == RUN) &&
                   (r_bit_cnt >= CW'(ADDR_START)) && (r_bit_cnt <= CW'(ADDR_END)) &&
                   (ADR_CHK != r_adr_ser);
    end
  end

  assign PAR_ERR = r_par_err;
`endif

  gray_phase_ctr u_phase (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_en   (EN),
    .i_load (w_ph_load),
    .i_step (w_ph_step),
    .o_ph   (T_PH)
  );

  assign BIT_CNT    = r_bit_cnt;
  assign WORD_ADR   = r_word_adr;
  assign WORD_START = r_word_start;
  assign SYNC       = r_sync;
  assign ADR_SER    = r_adr_ser;
  assign LOCK       = (r_state == RUN);
  assign SLIP       = r_slip;

endmodule

// File: tb/tb_serial_word_timing_gen.sv
// Scoreboard bench for serial_word_timing_gen at default geometry; define
// SERIAL_WORD_ADDR_PARITY_EN for both files to exercise the parity option.
module tb_serial_word_timing_gen;

  localparam int WB = 40;
  localparam int AB = 7;
  localparam int NW = 128;
  localparam int SP = 31;
  localparam int AS = 32;
  localparam int OW = 21;

  logic          CLK = 1'b0;
  logic          RST, EN, RESYNC;
  logic [5:0]    BIT_CNT;
  logic [AB-1:0] WORD_ADR;
  logic          WORD_START, SYNC, ADR_SER, LOCK, SLIP;
  logic [1:0]    T_PH;
`ifdef SERIAL_WORD_ADDR_PARITY_EN
  logic          ADR_CHK, PAR_ERR;
`endif

  serial_word_timing_gen dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .RESYNC     (RESYNC),
    .BIT_CNT    (BIT_CNT),
    .WORD_ADR   (WORD_ADR),
    .WORD_START (WORD_START),
    .SYNC       (SYNC),
    .ADR_SER    (ADR_SER),
    .T_PH       (T_PH),
    .LOCK       (LOCK),
    .SLIP       (SLIP)
`ifdef SERIAL_WORD_ADDR_PARITY_EN
    ,
    .ADR_CHK    (ADR_CHK),
    .PAR_ERR    (PAR_ERR)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];

  // reference model state
  logic       m_lock, m_slip, m_perr;
  int         m_bit, m_adr, m_ph;
  logic [1:0] gray_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_slip = 1'b0; m_perr = 1'b0;
    m_bit = 0; m_adr = 0; m_ph = 0;
  endtask

  function automatic logic model_ser();
    logic s;
    s = 1'b0;
    if (m_lock && m_bit >= AS && m_bit < AS + AB) s = m_adr[m_bit - AS];
`ifdef SERIAL_WORD_ADDR_PARITY_EN
    if (m_lock && m_bit == AS + AB) begin
      logic [AB-1:0] a;
      a = AB'(m_adr);
      s = ~^a;
    end
`endif
    return s;
  endfunction

  function automatic logic [OW-1:0] model_outs();
    logic ws, sy;
    ws = m_lock && (m_bit == 0);
    sy = m_lock && ((m_bit >= SP && m_bit <= SP + 2) || m_bit >= WB - 2);
    return {6'(m_bit), AB'(m_adr), ws, sy, model_ser(), gray_tbl[m_ph], m_lock, m_slip, m_perr};
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    logic pe;
    pe = 1'b0;
`ifdef SERIAL_WORD_ADDR_PARITY_EN
    pe = PAR_ERR;
`endif
    return {BIT_CNT, WORD_ADR, WORD_START, SYNC, ADR_SER, T_PH, LOCK, SLIP, pe};
  endfunction

  // driver: one bit time; expected outputs pushed, then popped after the edge
  task automatic cycle(input logic en, input logic rs, input logic flip);
    logic cur_ser;
    logic [OW-1:0] e;
    cur_ser = model_ser();
    EN = en;
    RESYNC = rs;
`ifdef SERIAL_WORD_ADDR_PARITY_EN
    ADR_CHK = cur_ser ^ flip;
    if (en) m_perr = m_lock && m_bit >= AS && m_bit <= AS + AB && flip;
`endif
    if (en) begin
      if (!m_lock) begin
        if (rs) begin
          m_lock = 1'b1; m_bit = 0; m_adr = 0; m_ph = 0;
        end
      end else if (rs && !(m_bit == WB - 1 && m_adr == NW - 1)) begin
        m_slip = 1'b1; m_bit = 0; m_adr = 0; m_ph = 0;
      end else begin
        m_bit++;
        if (m_bit == WB) begin
          m_bit = 0;
          m_adr = (m_adr + 1) % NW;
          m_ph  = (m_ph + 1) % 4;
        end
      end
    end
    exp_q.push_back(model_outs());
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("outs", 32'(dut_outs()), 32'(e));
    end
  endtask

  task automatic run_to(input int w, input int b);
    int n;
    n = 0;
    while (!(m_adr == w && m_bit == b) && n < 6000) begin
      cycle(1'b1, 1'b0, 1'b0);
      n++;
    end
    if (n >= 6000) check_eq("run_to_timeout", 32'(n), 32'd0);
  endtask

  initial begin : main
    logic [AB-1:0] ser_bits;
    int pe_cnt;
    RST = 1'b1; EN = 1'b0; RESYNC = 1'b0;
`ifdef SERIAL_WORD_ADDR_PARITY_EN
    ADR_CHK = 1'b0;
`endif
    model_reset();
    @(posedge CLK); #1;
    check_eq("reset", 32'(dut_outs()), 32'(model_outs()));
    // RESYNC coincident with reset is ignored
    EN = 1'b1; RESYNC = 1'b1;
    @(posedge CLK); #1;
    check_eq("rst_resync", 32'(dut_outs()), 32'(model_outs()));
    RST = 1'b0; RESYNC = 1'b0;

    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("no_lock", 32'(LOCK), 32'd0);

    cycle(1'b1, 1'b1, 1'b0);
    check_eq("lock_ws", 32'({LOCK, WORD_START, BIT_CNT}), 32'({1'b1, 1'b1, 6'd0}));
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);

    run_to(5, 31);
    for (int i = 0; i < AB; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      ser_bits[i] = ADR_SER;
    end
    check_eq("ser_word5", 32'(ser_bits), 32'h05);
    check_eq("ph_word5", 32'(T_PH), 32'h1);
`ifdef SERIAL_WORD_ADDR_PARITY_EN
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("parity_word5", 32'(ADR_SER), 32'd1);
    run_to(6, 32);
    pe_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b0, i == 3);
      if (PAR_ERR) pe_cnt++;
    end
    check_eq("par_err_pulses", 32'(pe_cnt), 32'd1);
`endif

    run_to(127, 39);
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("aligned_resync", 32'({SLIP, LOCK, WORD_ADR, BIT_CNT}), 32'({1'b0, 1'b1, 7'd0, 6'd0}));

    run_to(3, 17);
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("slip", 32'({SLIP, LOCK, WORD_ADR, BIT_CNT, T_PH}), 32'({1'b1, 1'b1, 7'd0, 6'd0, 2'b00}));

    for (int i = 0; i < 23; i++) cycle(1'b1, 1'b0, 1'b0);
    #2 RST = 1'b1;
    #1 model_reset();
    check_eq("async_reset", 32'(dut_outs()), 32'(model_outs()));
    @(posedge CLK); #1;
    RST = 1'b0;

    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, $urandom_range(0, 29) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
